// File: rtl/vga_rx.sv
// rtl/vga_rx.sv - VGA receiver: locks to sync timing, recovers pixel coordinates, flags timing errors
module vga_rx #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [2:0]  vga_rgb,
  input  logic        err_clr,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [2:0]  pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [15:0] frame_cnt,
  output logic        err_hlen,
  output logic        err_vlen
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_END  = 10'(V_SYNC);
  localparam logic [9:0] H_VIS0  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_VIS1  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_VIS0  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_VIS1  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] CNT_MAX = 10'h3ff;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state, state_nx;
  logic        s1_hs, s1_vs, p_hs, p_vs;
  logic [2:0]  s1_rgb;
  logic [9:0]  hcnt, vcnt, h_pos, v_pos;
  logic        h_seen;
  logic        hs_rise, hs_fall, vs_rise, vs_fall;
  logic        h_viol, v_viol, fs_nx, in_win;

  // Stage 1: syncs normalised to active-high; p_* hold the previous stage-1 value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      p_hs   <= 1'b0;
      p_vs   <= 1'b0;
      s1_rgb <= 3'd0;
    end else begin
      s1_hs  <= vga_hsync ^ SYNC_ACTIVE_LOW;
      s1_vs  <= vga_vsync ^ SYNC_ACTIVE_LOW;
      p_hs   <= s1_hs;
      p_vs   <= s1_vs;
      s1_rgb <= vga_rgb;
    end
  end

  // hcnt/vcnt hold the position of the previous stage-1 sample; h_pos/v_pos that of the current one
  always_comb begin
    hs_rise = s1_hs & ~p_hs;
    hs_fall = ~s1_hs & p_hs;
    vs_rise = s1_vs & ~p_vs;
    vs_fall = ~s1_vs & p_vs;

    h_pos = hcnt;
    if (hs_rise)
      h_pos = 10'd0;
    else if (hcnt != CNT_MAX)
      h_pos = hcnt + 10'd1;

    v_pos = vcnt;
    if (vs_rise)
      v_pos = 10'd0;
    else if (hs_rise && vcnt != CNT_MAX)
      v_pos = vcnt + 10'd1;

    h_viol = h_seen & ((hs_rise & (hcnt != H_LAST)) | (hs_fall & (hcnt != HS_LAST)));
    v_viol = (state != SEARCH) &
             ((vs_rise & (vcnt != V_LAST)) | (vs_fall & ~(hs_rise & (v_pos == VS_END))));

    in_win = (h_pos >= H_VIS0) && (h_pos <= H_VIS1) && (v_pos >= V_VIS0) && (v_pos <= V_VIS1);
  end

  always_comb begin
    state_nx = state;
    fs_nx    = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_rise)
          state_nx = ACQUIRE;
      end
      ACQUIRE: begin
        if (h_viol || v_viol) begin
          state_nx = SEARCH;
        end else if (vs_rise) begin
          state_nx = LOCKED;
          fs_nx    = 1'b1;
        end
      end
      LOCKED: begin
        if (h_viol || v_viol)
          state_nx = SEARCH;
        else if (vs_rise)
          fs_nx = 1'b1;
      end
      default: state_nx = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= SEARCH;
      hcnt   <= 10'd0;
      vcnt   <= 10'd0;
      h_seen <= 1'b0;
    end else begin
      state <= state_nx;
      hcnt  <= h_pos;
      vcnt  <= v_pos;
      // Line checks restart from the first hsync leading edge after falling back to SEARCH
      if (state_nx == SEARCH && state != SEARCH)
        h_seen <= 1'b0;
      else if (hs_rise)
        h_seen <= 1'b1;
    end
  end

  // Stage 2: registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 3'd0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      frame_cnt   <= 16'd0;
      err_hlen    <= 1'b0;
      err_vlen    <= 1'b0;
    end else begin
      pix_valid   <= (state_nx == LOCKED) & in_win;
      pix_x       <= h_pos - H_VIS0;
      pix_y       <= v_pos - V_VIS0;
      pix_rgb     <= s1_rgb;
      frame_start <= fs_nx;
      locked      <= (state_nx == LOCKED);
      frame_cnt   <= frame_cnt + {15'd0, fs_nx};
      err_hlen    <= h_viol | (err_hlen & ~err_clr);
      err_vlen    <= v_viol | (err_vlen & ~err_clr);
    end
  end

endmodule

// File: tb/tb_vga_rx.sv
// tb/tb_vga_rx.sv - randomized bench for vga_rx on a scaled-down raster, both sync polarities
module tb_vga_rx;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic reset;
  logic hs_n, vs_n, hs_p, vs_p, err_clr;
  logic [2:0] rgb;

  logic        n_valid, n_fs, n_lk, n_eh, n_ev, p_valid, p_fs, p_lk, p_eh, p_ev;
  logic [9:0]  n_x, n_y, p_x, p_y;
  logic [2:0]  n_rgb, p_rgb;
  logic [15:0] n_fc, p_fc;

  always #5 clk = ~clk;

  vga_rx #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
           .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE_LOW(1'b1)) u_neg (
    .clk(clk), .reset(reset), .vga_hsync(hs_n), .vga_vsync(vs_n), .vga_rgb(rgb),
    .err_clr(err_clr), .pix_valid(n_valid), .pix_x(n_x), .pix_y(n_y), .pix_rgb(n_rgb),
    .frame_start(n_fs), .locked(n_lk), .frame_cnt(n_fc), .err_hlen(n_eh), .err_vlen(n_ev));

  vga_rx #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
           .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE_LOW(1'b0)) u_pos (
    .clk(clk), .reset(reset), .vga_hsync(hs_p), .vga_vsync(vs_p), .vga_rgb(rgb),
    .err_clr(err_clr), .pix_valid(p_valid), .pix_x(p_x), .pix_y(p_y), .pix_rgb(p_rgb),
    .frame_start(p_fs), .locked(p_lk), .frame_cnt(p_fc), .err_hlen(p_eh), .err_vlen(p_ev));

  typedef struct {
    bit         valid;
    int         x;
    int         y;
    logic [2:0] rgb;
    bit         fs;
    bit         locked;
    bit         vh;
    bit         vv;
    bit         clr;
    int         fidx;
    logic [15:0] fcnt;
  } exp_t;

  exp_t q[$];
  int clean = 0;
  logic [15:0] fcnt_m = 16'd0;
  bit eh_m = 1'b0, ev_m = 1'b0;
  int vcount[16] = '{default: 0};
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  task automatic check_inst(input string p, input exp_t e, input logic v, input logic [9:0] x,
                            input logic [9:0] y, input logic [2:0] c, input logic fs,
                            input logic lk, input logic [15:0] fc, input logic eh, input logic ev);
    chk({p, "pix_valid"},   32'(v),  32'(e.valid));
    chk({p, "frame_start"}, 32'(fs), 32'(e.fs));
    chk({p, "locked"},      32'(lk), 32'(e.locked));
    chk({p, "frame_cnt"},   32'(fc), 32'(e.fcnt));
    chk({p, "err_hlen"},    32'(eh), 32'(eh_m));
    chk({p, "err_vlen"},    32'(ev), 32'(ev_m));
    if (e.valid) begin
      chk({p, "pix_x"},   32'(x), 32'(e.x));
      chk({p, "pix_y"},   32'(y), 32'(e.y));
      chk({p, "pix_rgb"}, 32'(c), 32'(e.rgb));
    end
  endtask

  task automatic check_zero(input string p, input logic v, input logic [9:0] x, input logic [9:0] y,
                            input logic [2:0] c, input logic fs, input logic lk,
                            input logic [15:0] fc, input logic eh, input logic ev);
    chk({p, "pix_valid"}, 32'(v), 0);
    chk({p, "pix_x"}, 32'(x), 0);
    chk({p, "pix_y"}, 32'(y), 0);
    chk({p, "pix_rgb"}, 32'(c), 0);
    chk({p, "frame_start"}, 32'(fs), 0);
    chk({p, "locked"}, 32'(lk), 0);
    chk({p, "frame_cnt"}, 32'(fc), 0);
    chk({p, "err_hlen"}, 32'(eh), 0);
    chk({p, "err_vlen"}, 32'(ev), 0);
  endtask

  // Flags at the output of sample e reflect err_clr driven with the following sample
  task automatic check_out(input exp_t e, input bit nclr);
    eh_m = e.vh | (eh_m & ~nclr);
    ev_m = e.vv | (ev_m & ~nclr);
    check_inst("neg ", e, n_valid, n_x, n_y, n_rgb, n_fs, n_lk, n_fc, n_eh, n_ev);
    check_inst("pos ", e, p_valid, p_x, p_y, p_rgb, p_fs, p_lk, p_fc, p_eh, p_ev);
    if (e.fidx >= 0 && n_valid) vcount[e.fidx]++;
  endtask

  // One pixel clock: check the sample driven two clocks ago, then drive the next one.
  // Lock model: two consecutive clean vsync leading edges lock; any violation starts over.
  task automatic step(input bit hs, input bit vs, input bit vs_edge, input bit vh, input bit vv,
                      input bit clr, input int x, input int y, input int fidx, input bit rst);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() >= 2) begin
      check_out(q[0], q[1].clr);
      q.delete(0);
    end
    if (rst) begin
      reset = 1'b0;
      #1;
      check_zero("neg rst ", n_valid, n_x, n_y, n_rgb, n_fs, n_lk, n_fc, n_eh, n_ev);
      check_zero("pos rst ", p_valid, p_x, p_y, p_rgb, p_fs, p_lk, p_fc, p_eh, p_ev);
      reset = 1'b1;
      q.delete();
      clean = 0;
      fcnt_m = 16'd0;
      eh_m = 1'b0;
      ev_m = 1'b0;
    end
    e.rgb = 3'($urandom);
    hs_n = ~hs;
    vs_n = ~vs;
    hs_p = hs;
    vs_p = vs;
    rgb = e.rgb;
    err_clr = clr;
    e.clr = clr;
    e.x = x;
    e.y = y;
    e.fidx = fidx;
    e.fs = 1'b0;
    e.vh = vh;
    e.vv = vv && (clean >= 1);
    if (vs_edge) begin
      clean = (clean == 2) ? 2 : clean + 1;
      e.fs = (clean == 2);
    end
    if (e.vh || e.vv) clean = 0;
    e.locked = (clean == 2);
    e.valid = e.locked && x >= 0 && x < HA && y >= 0 && y < VA;
    fcnt_m = fcnt_m + 16'(e.fs);
    e.fcnt = fcnt_m;
    q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1, 1'b0);
  endtask

  // short_l: that line loses its last pixel; vs_l: vsync width in lines
  task automatic run_frame(input int f, input int short_l, input int vs_l, input int rst_l,
                           input int clr_l, input int clr_p);
    bit prev_short;
    int len;
    prev_short = 1'b0;
    for (int l = 0; l < VT; l++) begin
      len = (l == short_l) ? HT - 1 : HT;
      for (int p = 0; p < len; p++)
        step(p < HS, l < vs_l, l == 0 && p == 0, prev_short && p == 0,
             vs_l != VS && l == vs_l && p == 0, l == clr_l && p == clr_p,
             p - (HS + HB), l - (VS + VB), f, l == rst_l && p == HS + HB + 2);
      prev_short = (l == short_l);
    end
  endtask

  initial begin
    int sl;
    reset = 1'b0;
    hs_n = 1'b1; vs_n = 1'b1; hs_p = 1'b0; vs_p = 1'b0;
    rgb = 3'd0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("neg init ", n_valid, n_x, n_y, n_rgb, n_fs, n_lk, n_fc, n_eh, n_ev);
    check_zero("pos init ", p_valid, p_x, p_y, p_rgb, p_fs, p_lk, p_fc, p_eh, p_ev);
    reset = 1'b1;

    repeat (2000) idle();

    for (int f = 0; f < 3; f++) run_frame(f, -1, VS, -1, -1, -1);
    chk("frame1 valid count", 32'(vcount[1]), 32'(HA * VA));
    chk("frame2 valid count", 32'(vcount[2]), 32'(HA * VA));
    chk("neg frame_cnt after 3 frames", 32'(n_fc), 2);
    chk("pos frame_cnt after 3 frames", 32'(p_fc), 2);

    sl = $urandom_range(VT - 2, 3);
    run_frame(3, sl, VS, -1, -1, -1);
    for (int f = 4; f < 7; f++) run_frame(f, -1, VS, -1, -1, -1);
    chk("err_hlen sticky after relock", 32'(n_eh), 1);
    chk("relocked after short line", 32'(n_lk), 1);

    run_frame(7, -1, 3, -1, -1, -1);
    sl = $urandom_range(VT - 2, 3);
    run_frame(8, sl, VS, -1, sl + 1, 1);
    run_frame(9, -1, VS, -1, -1, -1);
    run_frame(10, -1, VS, -1, $urandom_range(VT - 1, 0), 5);

    run_frame(11, -1, VS, $urandom_range(VT - 3, VS + VB), -1, -1);
    for (int f = 12; f < 15; f++) run_frame(f, -1, VS, -1, -1, -1);
    idle();
    idle();
    chk("neg frame_cnt after reset", 32'(n_fc), 2);
    chk("pos frame_cnt after reset", 32'(p_fc), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_rx.md
Name: vga_rx

Overview:
- Receive-side counterpart of the vga640x480 timing generator.
- Samples vga_hsync, vga_vsync and vga_rgb on the pixel clock and locks to the 640x480 frame timing.
- Recovers pixel coordinates and flags timing violations.
- Used as an on-chip frame-grabber/monitor front end: its pixel stream can be written into vgaram-style storage or checked by a bench. Runs in the vga_clk domain.

Parameters:
H_ACTIVE 640 visible pixels per line
H_FP 16 horizontal front porch, pixels
H_SYNC 96 hsync width, pixels
H_BP 48 horizontal back porch, pixels
V_ACTIVE 480 visible lines per frame
V_FP 10 vertical front porch, lines
V_SYNC 2 vsync width, lines
V_BP 33 vertical back porch, lines
SYNC_ACTIVE_LOW 1 1: syncs asserted low; 0: asserted high

Ports:
clk in 1 pixel clock; one sample per pixel
reset in 1 asynchronous, active-low reset
vga_hsync in 1 horizontal sync from the transmitter
vga_vsync in 1 vertical sync from the transmitter
vga_rgb in 3 pixel colour
err_clr in 1 synchronous clear of the sticky error flags
pix_valid out 1 pix_* hold a visible pixel of a locked frame
pix_x out 10 column 0..H_ACTIVE-1
pix_y out 10 row 0..V_ACTIVE-1
pix_rgb out 3 captured colour
frame_start out 1 one-cycle pulse at each vsync leading edge while locked
locked out 1 timing acquired
frame_cnt out 16 locked frames seen; wraps
err_hlen out 1 sticky: line period or hsync width wrong
err_vlen out 1 sticky: frame period or vsync width wrong

Behaviour:
- Reset (async, reset=0): all outputs 0, state SEARCH, counters 0, sync history set to inactive.
- Stage 1 registers raw inputs. hs/vs are normalised to active-high per SYNC_ACTIVE_LOW. Edge detection compares stage 1 with the previous stage 1 value.
- Stage 2 registers all outputs. Latency: pin sample at cycle n appears on pix_* at n+2.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL likewise (525).
- hcnt (10b):
  - Set to 0 on the hsync leading edge.
  - Otherwise increments, saturating at 1023.
- vcnt (10b):
  - Set to 0 on the vsync leading edge; this wins over a simultaneous hsync edge.
  - Otherwise increments on each hsync leading edge, saturating at 1023.
- Visible window: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - pix_x = hcnt-(H_SYNC+H_BP); pix_y = vcnt-(V_SYNC+V_BP).
  - pix_valid = locked & in window.
  - pix_x, pix_y and pix_rgb update every cycle; they are don't-care when pix_valid=0.
- Line checks. Both are gated: active only after the first hsync edge since reset or since SEARCH entry.
  - hsync leading edge with previous hcnt != H_TOTAL-1 -> hlen violation.
  - hsync trailing edge with hcnt != H_SYNC-1 -> hlen violation.
- Frame checks, evaluated only in ACQUIRE/LOCKED:
  - vsync leading edge with vcnt != V_TOTAL-1 -> vlen violation.
  - vsync trailing edge not on the hsync edge that makes vcnt == V_SYNC -> vlen violation.
- Any violation sets its sticky flag.
  - err_clr=1 clears both flags.
  - A new violation in the same cycle as err_clr wins; the flag stays set.
- FSM:
  - SEARCH: locked=0. First vsync leading edge -> ACQUIRE.
  - ACQUIRE: locked=0. Any violation -> SEARCH. Next vsync leading edge with no violation during the frame -> LOCKED. This edge also pulses frame_start.
  - LOCKED: locked=1. frame_start pulses at each vsync leading edge. Any violation -> SEARCH; locked and pix_valid drop on the next output cycle.
- frame_cnt increments on each frame_start pulse and wraps 65535->0. It is not cleared by loss of lock, only by reset.
- Reset asserted mid-frame returns immediately to the reset state. The block relocks after two vsync leading edges following release.
- Sync inputs that are static: saturating counters, no lock, no spurious pulses.

Test Plan:
- Nominal 640x480@800x525 stream, 3 frames, negative syncs -> locked rises with frame_start at the 2nd vsync edge. Frames 2+ give exactly 307200 pix_valid cycles each. First valid pixel is x=0,y=0 with the driven rgb at +2 cycles. Last valid pixel is x=639,y=479. frame_cnt=2 at the end.
- Locked; one line of 799 clocks -> err_hlen=1, locked=0 within 2 cycles, pix_valid=0. Relocks after 2 further clean vsync edges; err_hlen remains 1 until err_clr.
- Locked; vsync held 3 lines -> err_vlen=1 and SEARCH. Pulse err_clr in the same cycle as a fresh hlen violation -> err_hlen stays 1.
- SYNC_ACTIVE_LOW=0 with positive syncs -> behaviour identical to test 1.
- reset pulsed low at line 200 of a locked frame -> all outputs 0 immediately. locked re-asserts at the 2nd vsync edge after release; frame_cnt restarts at 1.
- Syncs held inactive for 2000 clocks -> no frame_start, no lock, no flags set.
